// File: rtl/mmio_pkg.sv
// Shared constants for the MEM-stage memory / memory-mapped I/O block.
//   - I/O register offsets within the 256-byte I/O page
//   - STATUS bit positions
//   - reset value of the timer compare register
package mmio_pkg;

  // I/O register offsets (word aligned, relative to the I/O page base)
  localparam logic [7:0] OFF_SWITCH = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h04;
  localparam logic [7:0] OFF_TIMER  = 8'h08;
  localparam logic [7:0] OFF_TCMP   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  // STATUS register layout (RW1C)
  localparam int unsigned STATUS_W  = 2;
  localparam int unsigned ST_TMATCH = 0;  // timer reached TIMER_CMP
  localparam int unsigned ST_SWCHG  = 1;  // debounced switches changed

  // Compare value out of reset: far from the timer's reset value of 0
  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/sw_debounce.sv
// Switch input conditioning for the board switches.
// A two-flop synchroniser brings the raw asynchronous switches into the clk domain. With
// SW_DEBOUNCE_EN defined, a change is only accepted once the synchronised value has been held,
// different from the accepted value, for DEBOUNCE_CYCLES consecutive cycles. Without it the
// synchroniser output is used directly and DEBOUNCE_CYCLES is ignored.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   sw_raw      in   raw asynchronous switch levels
//   sw_db       out  accepted (debounced) switch value
//   sw_changed  out  one-cycle pulse, high in the cycle whose edge updates sw_db
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_raw,
  output logic [7:0] sw_db,
  output logic       sw_changed
);

  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SW_DEBOUNCE_EN

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       db_q;
  logic [7:0]       db_d;
  logic             accept;

  // cnt_q counts cycles the synchronised value has been steady and different from db_q.
  // sync1_q != sync2_q means the synchronised value is about to move, which restarts the
  // count so that the new value must itself be held for the full window.
  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    accept = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync2_q;
        accept = 1'b1;
      end else if (sync1_q == sync2_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign sw_db      = db_q;
  assign sw_changed = accept;

`else

  // Synchroniser output used as-is; flag the edge on which it takes a new value.
  assign sw_db      = sync2_q;
  assign sw_changed = (sync1_q != sync2_q);

  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;

`endif

endmodule

// File: rtl/data_mem_io.sv
// MEM-stage data memory and memory-mapped I/O of the 5-stage pipeline.
// Addresses whose bits [31:8] match IO_BASE[31:8] hit the I/O page; all others go to a word
// RAM of RAM_WORDS entries (out-of-range indices read 0 and drop writes). Loads are
// combinational from addr and current state; stores commit on the rising clock edge.
//
// I/O page: SWITCH (RO), LED (RW), TIMER (RW, free running), TIMER_CMP (RW), STATUS (RW1C:
// bit0 timer match, bit1 switch change). Other offsets read 0 and ignore writes.
//
// Build option: define SW_DEBOUNCE_EN to debounce the switch input (see sw_debounce).
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset (RAM contents are kept)
//   mem_write_en  in   store strobe for addr
//   addr          in   byte address, bits [1:0] ignored
//   write_data    in   store data
//   switches      in   raw asynchronous board switches
//   leds          out  LED register
//   read_data     out  load data (zero latency)
//   timer_irq     out  STATUS timer-match bit
module data_mem_io
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS       = 64,
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic [31:0] read_data,
  output logic        timer_irq
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);

  // Address decode
  logic             is_io;
  logic             ram_hit;
  logic [IDX_W-1:0] ram_idx;
  logic [7:0]       io_off;

  assign is_io   = (addr[31:8] == IO_BASE[31:8]);
  // RAM_WORDS is a power of two, so in-range means every index bit above IDX_W is zero
  assign ram_hit = !is_io && (addr[31:IDX_W+2] == '0);
  assign ram_idx = addr[IDX_W+1:2];
  assign io_off  = {addr[7:2], 2'b00};

  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  // Word RAM: asynchronous read, write on the clock edge, no reset
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (rst_n && mem_write_en && ram_hit) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  // Switch conditioning
  logic [7:0] sw_db;
  logic       sw_changed;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (switches),
    .sw_db     (sw_db),
    .sw_changed(sw_changed)
  );

  // I/O registers
  logic [7:0]          led_q;
  logic [7:0]          led_d;
  logic [31:0]         timer_q;
  logic [31:0]         timer_d;
  logic [31:0]         tcmp_q;
  logic [31:0]         tcmp_d;
  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] status_d;
  logic                wr_io;

  assign wr_io = mem_write_en && is_io;

  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q + 32'd1;
    tcmp_d   = tcmp_q;
    status_d = status_q;

    if (wr_io) begin
      case (io_off)
        OFF_LED:    led_d    = write_data[7:0];
        OFF_TIMER:  timer_d  = write_data;
        OFF_TCMP:   tcmp_d   = write_data;
        OFF_STATUS: status_d = status_q & ~write_data[STATUS_W-1:0];
        default:    ;
      endcase
    end

    // Set events are applied after the clear so they win when both land together
    if (timer_q == tcmp_q) begin
      status_d[ST_TMATCH] = 1'b1;
    end
    if (sw_changed) begin
      status_d[ST_SWCHG] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q    <= '0;
      timer_q  <= '0;
      tcmp_q   <= TIMER_CMP_RST;
      status_q <= '0;
    end else begin
      led_q    <= led_d;
      timer_q  <= timer_d;
      tcmp_q   <= tcmp_d;
      status_q <= status_d;
    end
  end

  // Load path
  always_comb begin
    read_data = '0;
    if (is_io) begin
      case (io_off)
        OFF_SWITCH: read_data = {24'b0, sw_db};
        OFF_LED:    read_data = {24'b0, led_q};
        OFF_TIMER:  read_data = timer_q;
        OFF_TCMP:   read_data = tcmp_q;
        OFF_STATUS: read_data = {{(32 - STATUS_W){1'b0}}, status_q};
        default:    read_data = '0;
      endcase
    end else if (ram_hit) begin
      read_data = ram_q[ram_idx];
    end
  end

  assign leds      = led_q;
  assign timer_irq = status_q[ST_TMATCH];

endmodule
